// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate truth-table sweeper.
//   OP_*    : gate operation codes selected on the op port.
//   state_e : sweeper FSM state encoding.
package gate_sweep_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the gate under test.
//   op    : operation code (gate_sweep_pkg OP_*)
//   vec   : input vector, vec[N_IN-1] is the first input
//   exp_y : expected gate output; reserved op gives 0
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op,
  input  logic [N_IN-1:0] vec,
  output logic            exp_y
);

  always_comb begin
    exp_y = 1'b0;
    case (op)
      OP_AND:  exp_y = &vec;
      OP_OR:   exp_y = |vec;
      OP_NAND: exp_y = ~&vec;
      OP_NOR:  exp_y = ~|vec;
      OP_XOR:  exp_y = ^vec;
      OP_XNOR: exp_y = ~^vec;
      OP_NOT:  exp_y = ~vec[N_IN-1];
      default: exp_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_sweeper.sv
// Truth-table sequencer: walks every input vector of an N_IN-input gate,
// holds each for SETTLE cycles, samples the gate output and checks it
// against the reference model for the latched op.
//   clk, rst        : clock and synchronous active-high reset
//   start, op       : sweep request and gate op (op 7 never starts a sweep)
//   stim            : vector driven to the gate under test
//   dut_y           : gate under test output, sampled only in CHECK
//   busy, done      : sweep running / sweep finished
//   pass            : valid with done, 1 when no vector mismatched
//   err_cnt         : saturating mismatch count
//   first_fail_vld  : a mismatch occurred in this sweep
//   first_fail_vec  : stim value of the first mismatch
module gate_truth_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_fail_vld,
  output logic [N_IN-1:0]  first_fail_vec
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [N_IN-1:0]  ffvec_q, ffvec_d;

  logic exp_y;
  logic mismatch;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .op    (op_q),
    .vec   (stim_q),
    .exp_y (exp_y)
  );

  assign mismatch = (dut_y != exp_y);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && (op != OP_RSVD)) begin
          state_d = ST_APPLY;
          cnt_d   = '0;
          stim_d  = '0;
          op_d    = op;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
        end
      end
      ST_APPLY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = stim_q;
          end
        end
        if (stim_q == '1) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // first_fail_vld doubles as the sticky mismatch flag, so pass
          // stays correct even when err_cnt has saturated.
          pass_d  = !(ffv_q || mismatch);
        end else begin
          state_d = ST_APPLY;
          stim_d  = stim_q + 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stim_q  <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Bench for gate_truth_sweeper: three instances (N_IN=2/ERR_W=8,
// N_IN=3/ERR_W=8, N_IN=3/ERR_W=2), each beside a bench-selected gate.
module tb_gate_truth_sweeper;

  localparam int S = 2;
  localparam int NN  [3] = '{2, 3, 3};
  localparam int EWA [3] = '{8, 8, 2};

  // gate kinds wired as the gate under test
  localparam int G_NOR = 0, G_AND = 1, G_XOR = 2, G_ZERO = 3;

  typedef struct packed {
    int stim; int busy; int done; int pass; int err; int ffv; int ffvec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_a, start_b, start_c;
  logic [2:0] op_a, op_b, op_c;
  int         gate_a, gate_b, gate_c;

  logic [1:0] stim_a;  logic [2:0] stim_b;  logic [2:0] stim_c;
  logic       y_a, y_b, y_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic       pass_a, pass_b, pass_c, ffv_a, ffv_b, ffv_c;
  logic [7:0] err_a, err_b;  logic [1:0] err_c;
  logic [1:0] ffvec_a;  logic [2:0] ffvec_b;  logic [2:0] ffvec_c;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic int ones(int v, int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += (v >> i) & 1;
    return c;
  endfunction

  function automatic int bench_gate(int gk, int v, int n);
    int c = ones(v, n);
    case (gk)
      G_NOR:   return (c == 0) ? 1 : 0;
      G_AND:   return (c == n) ? 1 : 0;
      G_XOR:   return c % 2;
      default: return 0;
    endcase
  endfunction

  function automatic int bench_op(int op, int v, int n);
    int c = ones(v, n);
    case (op)
      0: return (c == n) ? 1 : 0;
      1: return (c > 0) ? 1 : 0;
      2: return (c != n) ? 1 : 0;
      3: return (c == 0) ? 1 : 0;
      4: return c % 2;
      5: return 1 - (c % 2);
      6: return (((v >> (n - 1)) & 1) == 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Expected outputs k cycles after the accepting edge (k=0 is the cycle
  // right after it). Vector v is visible for k in [v*(S+1), (v+1)*(S+1))
  // and its verdict shows up once that window has ended.
  function automatic exp_t model(int n, int s, int ew, int md, int k, int op, int gk);
    exp_t e;
    int   tlen, nv, cnt, emax;
    e = '0;
    if (md == 0) return e;
    tlen = (1 << n) * (s + 1);
    if (k >= tlen) begin
      nv = 1 << n;  e.stim = (1 << n) - 1;  e.done = 1;
    end else begin
      nv = k / (s + 1);  e.stim = nv;  e.busy = 1;
    end
    cnt = 0;
    for (int v = 0; v < nv; v++) begin
      if (bench_gate(gk, v, n) != bench_op(op, v, n)) begin
        if (cnt == 0) begin e.ffv = 1; e.ffvec = v; end
        cnt++;
      end
    end
    emax  = (1 << ew) - 1;
    e.err = (cnt > emax) ? emax : cnt;
    e.pass = (e.done == 1 && cnt == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s at t=%0t got=%0d want=%0d", nm, $time, got, want);
    end
  endtask

  assign y_a = (bench_gate(gate_a, int'(stim_a), NN[0]) != 0);
  assign y_b = (bench_gate(gate_b, int'(stim_b), NN[1]) != 0);
  assign y_c = (bench_gate(gate_c, int'(stim_c), NN[2]) != 0);

  gate_truth_sweeper #(.N_IN(2), .SETTLE(S), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .op(op_a), .stim(stim_a), .dut_y(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_fail_vld(ffv_a), .first_fail_vec(ffvec_a));

  gate_truth_sweeper #(.N_IN(3), .SETTLE(S), .ERR_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .op(op_b), .stim(stim_b), .dut_y(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_fail_vld(ffv_b), .first_fail_vec(ffvec_b));

  gate_truth_sweeper #(.N_IN(3), .SETTLE(S), .ERR_W(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .op(op_c), .stim(stim_c), .dut_y(y_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c),
    .first_fail_vld(ffv_c), .first_fail_vec(ffvec_c));

  // Model bookkeeping: which sweep each instance is in and when it began.
  int cyc = 0;
  int mode [3] = '{0, 0, 0};
  int t0   [3] = '{0, 0, 0};
  int mop  [3] = '{0, 0, 0};
  int mgk  [3] = '{0, 0, 0};

  always @(posedge clk) begin
    logic [2:0] sv;
    int         ov [3];
    int         gv [3];
    sv = {start_c, start_b, start_a};
    ov = '{int'(op_a), int'(op_b), int'(op_c)};
    gv = '{gate_a, gate_b, gate_c};
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mode[i] <= 0;
      end else if (sv[i] && ov[i] != 7 &&
                   (mode[i] == 0 || (cyc - t0[i] - 1) >= (1 << NN[i]) * (S + 1))) begin
        mode[i] <= 1;
        t0[i]   <= cyc;
        mop[i]  <= ov[i];
        mgk[i]  <= gv[i];
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        int   a [7];
        e = model(NN[i], S, EWA[i], mode[i], cyc - t0[i] - 1, mop[i], mgk[i]);
        case (i)
          0: a = '{int'(stim_a), int'(busy_a), int'(done_a), int'(pass_a), int'(err_a), int'(ffv_a), int'(ffvec_a)};
          1: a = '{int'(stim_b), int'(busy_b), int'(done_b), int'(pass_b), int'(err_b), int'(ffv_b), int'(ffvec_b)};
          default: a = '{int'(stim_c), int'(busy_c), int'(done_c), int'(pass_c), int'(err_c), int'(ffv_c), int'(ffvec_c)};
        endcase
        check($sformatf("inst%0d.stim", i),  a[0], e.stim);
        check($sformatf("inst%0d.busy", i),  a[1], e.busy);
        check($sformatf("inst%0d.done", i),  a[2], e.done);
        check($sformatf("inst%0d.pass", i),  a[3], e.pass);
        check($sformatf("inst%0d.err", i),   a[4], e.err);
        check($sformatf("inst%0d.ffv", i),   a[5], e.ffv);
        check($sformatf("inst%0d.ffvec", i), a[6], e.ffvec);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t m;
    rst = 1'b1;
    start_a = 0; start_b = 0; start_c = 0;
    op_a = 0; op_b = 0; op_c = 0;
    gate_a = G_NOR; gate_b = G_XOR; gate_c = G_ZERO;

    // pin the model against hand-worked results
    m = model(2, 2, 8, 1, 12, 3, G_AND);
    check("model.and_as_nor.err", m.err, 2);
    m = model(2, 2, 8, 1, 4, 3, G_NOR);
    check("model.k4.stim", m.stim, 1);
    m = model(3, 2, 2, 1, 24, 2, G_ZERO);
    check("model.nand_sat.err", m.err, 3);

    step(2);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset.busy_a", int'(busy_a), 0);
    check("reset.err_b", int'(err_b), 0);

    // correct NOR, op=3
    op_a = 3; start_a = 1; step(1); start_a = 0;
    step(11);
    check("nor.done_k11", int'(done_a), 0);
    step(1);
    check("nor.done_k12", int'(done_a), 1);
    check("nor.pass", int'(pass_a), 1);
    check("nor.err", int'(err_a), 0);
    check("nor.ffv", int'(ffv_a), 0);

    // AND wired where NOR expected, restart from DONE
    gate_a = G_AND; op_a = 3; start_a = 1; step(1); start_a = 0;
    step(13);
    check("and_as_nor.err", int'(err_a), 2);
    check("and_as_nor.ffvec", int'(ffvec_a), 0);
    check("and_as_nor.pass", int'(pass_a), 0);

    // reset during vector 10, then a clean sweep
    gate_a = G_NOR; start_a = 1; step(1); start_a = 0;
    step(7);
    check("midreset.stim_before", int'(stim_a), 2);
    rst = 1; step(1); rst = 0;
    check("midreset.stim", int'(stim_a), 0);
    check("midreset.busy", int'(busy_a), 0);
    start_a = 1; step(1); start_a = 0;
    step(13);
    check("after_reset.pass", int'(pass_a), 1);

    // start while busy is ignored
    start_a = 1; step(1); start_a = 0;
    step(4);
    op_a = 5; start_a = 1; step(1); start_a = 0; op_a = 3;
    step(8);
    check("busy_start.done", int'(done_a), 1);
    check("busy_start.pass", int'(pass_a), 1);

    // op=7 in IDLE is ignored
    rst = 1; step(1); rst = 0;
    op_a = 7; start_a = 1; step(1); start_a = 0;
    step(2);
    check("rsvd.busy", int'(busy_a), 0);

    // N_IN=3 correct XOR, then restart as XNOR
    op_b = 4; start_b = 1; step(1); start_b = 0;
    step(23);
    check("xor.done_k23", int'(done_b), 0);
    step(1);
    check("xor.done_k24", int'(done_b), 1);
    check("xor.pass", int'(pass_b), 1);
    op_b = 5; start_b = 1; step(1); start_b = 0;
    step(24);
    check("xnor.err", int'(err_b), 8);
    check("xnor.ffvec", int'(ffvec_b), 0);

    // ERR_W=2 saturation with dut_y tied low, op NAND
    op_c = 2; start_c = 1; step(1); start_c = 0;
    step(24);
    check("sat.err", int'(err_c), 3);
    check("sat.pass", int'(pass_c), 0);
    check("sat.ffvec", int'(ffvec_c), 0);
    check("sat.ffv", int'(ffv_c), 1);

    step(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
